// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store unit: beat sizes, funct3 encodings and FSM states.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_SD      = 3'b011;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_B0_ADDR = 3'd1,
    S_B0_DATA = 3'd2,
    S_B1_ADDR = 3'd3,
    S_B1_DATA = 3'd4,
    S_RESP    = 3'd5
  } mau_state_t;

  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: byte strobes and store data shifted into a
// two-word window, plus extraction and sign/zero extension of merged load data.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter  int XLEN  = 64,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  msize_t              size,
  input  logic [OFF_W-1:0]    offset,
  input  logic                zext,
  input  logic [XLEN-1:0]     wdata,
  input  logic [2*XLEN-1:0]   rbuf,
  output logic [2*BYTES-1:0]  strobe,
  output logic [2*XLEN-1:0]   wdata_sh,
  output logic [XLEN-1:0]     rdata
);

  int               nbytes;
  logic             sbit;
  logic [BYTES-1:0] bmask;
  logic [XLEN-1:0]  wmasked;
  logic [XLEN-1:0]  raw;

  always_comb begin
    nbytes  = 1;
    sbit    = 1'b0;
    bmask   = '0;
    wmasked = '0;
    rdata   = '0;
    raw     = XLEN'(rbuf >> {offset, 3'b000});
    case (size)
      MSIZE1:  begin nbytes = 1; sbit = raw[7];  end
      MSIZE2:  begin nbytes = 2; sbit = raw[15]; end
      MSIZE4:  begin nbytes = 4; sbit = raw[31]; end
      default: begin nbytes = 8; sbit = raw[XLEN-1]; end
    endcase
    for (int i = 0; i < BYTES; i++) bmask[i] = (i < nbytes);
    // Upper store bits are dropped so they never leak into a second beat's lanes.
    for (int i = 0; i < XLEN; i++) begin
      wmasked[i] = (i < 8 * nbytes) ? wdata[i] : 1'b0;
      rdata[i]   = (i < 8 * nbytes) ? raw[i] : (!zext && sbit);
    end
    strobe   = {{BYTES{1'b0}}, bmask} << offset;
    wdata_sh = {{XLEN{1'b0}}, wmasked} << {offset, 3'b000};
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between MEM stage and data bus. Define MEM_MISALIGN_SPLIT_EN to
// split/merge misaligned accesses; otherwise they complete with resp_misalign.
//
// state     | meaning
// ----------|------------------------------------------------
// S_IDLE    | ready for a request
// S_B0_ADDR | first beat presented, waiting for addr_ok
// S_B0_DATA | first beat accepted, waiting for data_ok
// S_B1_ADDR | second (next word) beat presented
// S_B1_DATA | second beat accepted, waiting for data_ok
// S_RESP    | one-cycle completion pulse
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int XLEN   = 64,
  parameter  int ADDR_W = 64,
  localparam int BYTES  = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_fun3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misalign,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [BYTES-1:0]  dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data
);

  localparam int     OFF_W     = $clog2(BYTES);
  localparam msize_t WORD_SIZE = (XLEN == 64) ? MSIZE8 : MSIZE4;

  mau_state_t          state_q, state_d;
  logic                write_q;
  logic [2:0]          fun3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic                mis_q, cross_q;
  logic [2*XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]     rdata_q;
  logic                misalign_q;
  logic [2:0]          cls_in;
  logic                in_ill, in_mis, mis_fault, in_fault;
  logic                accept, cap0, cap1;
  logic [ADDR_W-1:0]   word_addr;
  msize_t              acc_size;
  logic [2*BYTES-1:0]  strobe_w;
  logic [2*XLEN-1:0]   wdata_w;
  logic [XLEN-1:0]     rdata_ext;

  // Returns {illegal, misaligned, crosses_word} for a request.
  function automatic logic [2:0] classify(input logic write, input logic [2:0] f3,
                                          input logic [OFF_W-1:0] off);
    int   nbytes;
    int   offi;
    logic ill, mis, crs;
    nbytes = size_bytes(f3[1:0]);
    offi   = int'(off);
    ill    = (f3 == F3_ILLEGAL) || (write && f3[2]) || (nbytes > BYTES);
    mis    = (offi & (nbytes - 1)) != 0;
    crs    = (offi + nbytes) > BYTES;
    return {ill, mis, crs};
  endfunction

  assign cls_in   = classify(req_write, req_fun3, req_addr[OFF_W-1:0]);
  assign in_ill   = cls_in[2];
  assign in_mis   = cls_in[1];
`ifdef MEM_MISALIGN_SPLIT_EN
  assign mis_fault = 1'b0;
`else
  assign mis_fault = in_mis;
`endif
  assign in_fault  = in_ill || mis_fault;
  assign accept    = req_valid && (state_q == S_IDLE);
  assign word_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign acc_size  = msize_t'({1'b0, fun3_q[1:0]});

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size     (acc_size),
    .offset   (addr_q[OFF_W-1:0]),
    .zext     (fun3_q[2]),
    .wdata    (wdata_q),
    .rbuf     (buf_d),
    .strobe   (strobe_w),
    .wdata_sh (wdata_w),
    .rdata    (rdata_ext)
  );

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = 3'd0;
    dreq_strobe = '0;
    dreq_data   = '0;
    cap0        = 1'b0;
    cap1        = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = in_fault ? S_RESP : S_B0_ADDR;
      end
      S_B0_ADDR: begin
        dreq_valid = 1'b1;
        dreq_addr  = mis_q ? word_addr : addr_q;
        dreq_size  = mis_q ? WORD_SIZE : acc_size;
        if (write_q) begin
          dreq_strobe = strobe_w[BYTES-1:0];
          dreq_data   = wdata_w[XLEN-1:0];
        end
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            cap0    = 1'b1;
            state_d = cross_q ? S_B1_ADDR : S_RESP;
          end else begin
            state_d = S_B0_DATA;
          end
        end
      end
      S_B0_DATA: begin
        if (dresp_data_ok) begin
          cap0    = 1'b1;
          state_d = cross_q ? S_B1_ADDR : S_RESP;
        end
      end
      S_B1_ADDR: begin
        dreq_valid = 1'b1;
        dreq_addr  = word_addr + ADDR_W'(BYTES);
        dreq_size  = WORD_SIZE;
        if (write_q) begin
          dreq_strobe = strobe_w[2*BYTES-1:BYTES];
          dreq_data   = wdata_w[2*XLEN-1:XLEN];
        end
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            cap1    = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_B1_DATA;
          end
        end
      end
      S_B1_DATA: begin
        if (dresp_data_ok) begin
          cap1    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat 0 fills the low word of the merge window, beat 1 the high word.
  always_comb begin
    buf_d = buf_q;
    if (cap0) buf_d[XLEN-1:0]      = dresp_data;
    if (cap1) buf_d[2*XLEN-1:XLEN] = dresp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      fun3_q     <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      cross_q    <= 1'b0;
      buf_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= accept ? '0 : buf_d;
      if (accept) begin
        write_q <= req_write;
        fun3_q  <= req_fun3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mis_q   <= in_mis;
        cross_q <= cls_in[0];
      end
      if (state_d == S_RESP && state_q != S_RESP) begin
        rdata_q    <= (state_q == S_IDLE || write_q) ? '0 : rdata_ext;
        misalign_q <= (state_q == S_IDLE) && !in_ill && mis_fault;
      end else if (state_q == S_RESP) begin
        rdata_q    <= '0;
        misalign_q <= 1'b0;
      end
    end
  end

  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=64): vector table plus multi-cycle sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid, req_ready, req_write;
  logic [2:0]        req_fun3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid, resp_misalign;
  logic [XLEN-1:0]   resp_rdata;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [XLEN-1:0]   dreq_data;
  logic              dresp_addr_ok, dresp_data_ok;
  logic [XLEN-1:0]   dresp_data;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  typedef struct {
    string       name;
    logic        write;
    logic [2:0]  fun3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] bus;
    logic        nobeat;
    logic [63:0] e_addr;
    logic [2:0]  e_size;
    logic [7:0]  e_strobe;
    logic [63:0] e_data;
    logic [63:0] e_rdata;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(string n, logic w, logic [2:0] f3, logic [63:0] a,
                              logic [63:0] wd, logic [63:0] bus, logic nb,
                              logic [63:0] ea, logic [2:0] es, logic [7:0] est,
                              logic [63:0] ed, logic [63:0] er, logic em);
    vec_t v;
    v.name = n; v.write = w; v.fun3 = f3; v.addr = a; v.wdata = wd; v.bus = bus;
    v.nobeat = nb; v.e_addr = ea; v.e_size = es; v.e_strobe = est; v.e_data = ed;
    v.e_rdata = er; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    @(negedge clk);
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_fun3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_beat(input string n, input logic [63:0] ea, input logic [2:0] es,
                            input logic [7:0] est, input logic [63:0] ed);
    chk({n, ".valid"},  dreq_valid, 1'b1);
    chk({n, ".addr"},   dreq_addr, ea);
    chk({n, ".size"},   dreq_size, es);
    chk({n, ".strobe"}, dreq_strobe, est);
    chk({n, ".data"},   dreq_data, ed);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.write, v.fun3, v.addr, v.wdata);
    if (v.nobeat) begin
      chk({v.name, ".nobeat"}, dreq_valid, 1'b0);
    end else begin
      check_beat(v.name, v.e_addr, v.e_size, v.e_strobe, v.e_data);
      chk({v.name, ".early_resp"}, resp_valid, 1'b0);
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = v.bus;
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    end
    chk({v.name, ".resp_valid"}, resp_valid, 1'b1);
    chk({v.name, ".rdata"},      resp_rdata, v.e_rdata);
    chk({v.name, ".misalign"},   resp_misalign, v.e_mis);
    @(negedge clk);
    chk({v.name, ".resp_pulse"}, resp_valid, 1'b0);
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_fun3 = 0; req_addr = 0; req_wdata = 0;
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;

    vecs.push_back(mk("lb",  0, F3_LB,  64'h1003, 0, 64'h0000_0000_8000_0000, 0,
                      64'h1003, MSIZE1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0));
    vecs.push_back(mk("sh",  1, F3_SH,  64'h2006, 64'hABCD, 0, 0,
                      64'h2006, MSIZE2, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 0));
    vecs.push_back(mk("lbu", 0, F3_LBU, 64'h1003, 0, 64'h0000_0000_8000_0000, 0,
                      64'h1003, MSIZE1, 8'h00, 64'h0, 64'h80, 0));
    vecs.push_back(mk("lh",  0, F3_LH,  64'h1002, 0, 64'h0000_0000_8001_0000, 0,
                      64'h1002, MSIZE2, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0));
    vecs.push_back(mk("lhu", 0, F3_LHU, 64'h1002, 0, 64'h0000_0000_8001_0000, 0,
                      64'h1002, MSIZE2, 8'h00, 64'h0, 64'h8001, 0));
    vecs.push_back(mk("lw",  0, F3_LW,  64'h1004, 0, 64'h8765_4321_0000_0000, 0,
                      64'h1004, MSIZE4, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 0));
    vecs.push_back(mk("lwu", 0, F3_LWU, 64'h1004, 0, 64'h8765_4321_0000_0000, 0,
                      64'h1004, MSIZE4, 8'h00, 64'h0, 64'h8765_4321, 0));
    vecs.push_back(mk("ld",  0, F3_LD,  64'h1008, 0, 64'h1122_3344_5566_7788, 0,
                      64'h1008, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 0));
    vecs.push_back(mk("sb",  1, F3_SB,  64'h3005, 64'hFFFF_FF5A, 0, 0,
                      64'h3005, MSIZE1, 8'h20, 64'h0000_5A00_0000_0000, 64'h0, 0));
    vecs.push_back(mk("sw",  1, F3_SW,  64'h3004, 64'h1234_5678_DEAD_BEEF, 0, 0,
                      64'h3004, MSIZE4, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0));
    vecs.push_back(mk("sd",  1, F3_SD,  64'h3000, 64'h0123_4567_89AB_CDEF, 0, 0,
                      64'h3000, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 0));
    vecs.push_back(mk("ill_f3",    0, F3_ILLEGAL, 64'h1000, 0, 0, 1, 0, 0, 0, 0, 64'h0, 0));
    vecs.push_back(mk("ill_f3_mis",0, F3_ILLEGAL, 64'h1003, 0, 0, 1, 0, 0, 0, 0, 64'h0, 0));
    vecs.push_back(mk("ill_store", 1, 3'b100,     64'h1000, 0, 0, 1, 0, 0, 0, 0, 64'h0, 0));
`ifdef MEM_MISALIGN_SPLIT_EN
    vecs.push_back(mk("lh_mis", 0, F3_LH, 64'h1001, 0, 64'h0000_0000_00BB_AA00, 0,
                      64'h1000, MSIZE8, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_BBAA, 0));
    vecs.push_back(mk("sw_mis", 1, F3_SW, 64'h3002, 64'h1122_3344, 0, 0,
                      64'h3000, MSIZE8, 8'h3C, 64'h0000_1122_3344_0000, 64'h0, 0));
`else
    vecs.push_back(mk("lh_mis", 0, F3_LH, 64'h1001, 0, 0, 1, 0, 0, 0, 0, 64'h0, 1));
    vecs.push_back(mk("sw_mis", 1, F3_SW, 64'h3002, 64'h1122_3344, 0, 1, 0, 0, 0, 0, 64'h0, 1));
    vecs.push_back(mk("lw_cross", 0, F3_LW, 64'h100E, 0, 0, 1, 0, 0, 0, 0, 64'h0, 1));
    vecs.push_back(mk("ld_cross", 0, F3_LD, 64'h1004, 0, 0, 1, 0, 0, 0, 0, 64'h0, 1));
`endif

    repeat (2) @(negedge clk);
    chk("rst.req_ready",   req_ready, 1'b1);
    chk("rst.resp_valid",  resp_valid, 1'b0);
    chk("rst.resp_rdata",  resp_rdata, 64'h0);
    chk("rst.misalign",    resp_misalign, 1'b0);
    chk("rst.dreq_valid",  dreq_valid, 1'b0);
    chk("rst.dreq_addr",   dreq_addr, 64'h0);
    chk("rst.dreq_size",   dreq_size, 3'd0);
    chk("rst.dreq_strobe", dreq_strobe, 8'h0);
    chk("rst.dreq_data",   dreq_data, 64'h0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef MEM_MISALIGN_SPLIT_EN
    // Crossing load: beat0 takes the addr_ok then data_ok path, beat1 both at once.
    issue(0, F3_LW, 64'h100E, 0);
    check_beat("lwx.b0", 64'h1008, MSIZE8, 8'h00, 64'h0);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("lwx.b0_data_idle", dreq_valid, 1'b0);
    dresp_data_ok = 1'b1; dresp_data = 64'h2211_0000_0000_0000;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    check_beat("lwx.b1", 64'h1010, MSIZE8, 8'h00, 64'h0);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_0000_4433;
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("lwx.resp_valid", resp_valid, 1'b1);
    chk("lwx.rdata", resp_rdata, 64'h0000_0000_4433_2211);
    @(negedge clk);

    issue(1, F3_SW, 64'h300E, 64'hAABB_CCDD);
    check_beat("swx.b0", 64'h3008, MSIZE8, 8'hC0, 64'hCCDD_0000_0000_0000);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    @(negedge clk);
    check_beat("swx.b1", 64'h3010, MSIZE8, 8'h03, 64'h0000_0000_0000_AABB);
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("swx.resp_valid", resp_valid, 1'b1);
    chk("swx.rdata", resp_rdata, 64'h0);
    @(negedge clk);
`endif

    // Delayed addr_ok: beat must hold stable for four cycles.
    issue(0, F3_LD, 64'h2000, 0);
    for (int c = 0; c < 4; c++) begin
      check_beat($sformatf("hold%0d", c), 64'h2000, MSIZE8, 8'h00, 64'h0);
      chk($sformatf("hold%0d.resp", c), resp_valid, 1'b0);
      if (c == 3) begin
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'hCAFE_F00D_1234_5678;
      end
      @(negedge clk);
    end
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("hold.resp_valid", resp_valid, 1'b1);
    chk("hold.rdata", resp_rdata, 64'hCAFE_F00D_1234_5678);
    @(negedge clk);
    chk("hold.resp_pulse", resp_valid, 1'b0);

    // Reset while waiting for data_ok, then a stale data_ok in IDLE.
    issue(0, F3_LW, 64'h1000, 0);
    chk("rmid.valid", dreq_valid, 1'b1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("rmid.b0_data", dreq_valid, 1'b0);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    chk("rmid.ready", req_ready, 1'b1);
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("rmid.no_resp", resp_valid, 1'b0);
    chk("rmid.no_beat", dreq_valid, 1'b0);
    chk("rmid.ready2", req_ready, 1'b1);
    @(negedge clk);
    chk("rmid.no_resp2", resp_valid, 1'b0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
